tea_block_packer: RTL

// - Upstream feeder for tea_accelerator: packs a 32-bit AXI-Stream word stream into 64-bit TEA blocks.
// - Drives tea_accelerator i_axis_valid_s / i_axis_data_s and consumes its o_axis_ready_s as i_axis_ready_m.
// - Pads an odd-length message (tlast on a block's first word) with PAD_WORD so every block is complete.
// - Tracks the number of blocks handed off and whether a half block is pending.

---
 rtl/tea_block_packer.sv | 101 ++++++++++
 1 files changed

// File: rtl/tea_block_packer.sv
// tea_block_packer: packs a stream of 32-bit AXI-Stream words into 64-bit TEA blocks.
// The first word of each block goes to the upper half (v0) and the second word to the
// lower half (v1). If tlast arrives on the first word of a block, the lower half is
// filled with PAD_WORD. The output stage is a single register slice, so valid, data and
// last are all registered, and valid never depends combinationally on ready.
module tea_block_packer #(
  parameter logic [31:0] PAD_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_axis_valid_s,
  output logic             o_axis_ready_s,
  input  logic [31:0]      i_axis_data_s,
  input  logic             i_axis_last_s,
  output logic             o_axis_valid_m,
  input  logic             i_axis_ready_m,
  output logic [63:0]      o_axis_data_m,
  output logic             o_axis_last_m,
  output logic [CNT_W-1:0] o_block_count,
  output logic             o_half_pending
);

  // Block assembly state: either no word is held, or the upper word is waiting.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HALF  = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_hi_word;
  logic             r_valid;
  logic [63:0]      r_data;
  logic             r_last;
  logic [CNT_W-1:0] r_count;

  logic w_ready_s;
  logic w_accept;
  logic w_drain;
  logic w_load;

  // Input side is ready whenever the output slot is empty or is being emptied this cycle.
  assign w_ready_s = !r_valid || i_axis_ready_m;
  assign w_accept  = i_axis_valid_s && w_ready_s;
  assign w_drain   = r_valid && i_axis_ready_m;
  // A block completes when the second word arrives, or when tlast closes a block early.
  assign w_load    = w_accept && ((r_state == S_HALF) || i_axis_last_s);

  // Assembly FSM, output register slice and handoff counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_EMPTY;
      r_hi_word <= 32'h0;
      r_valid   <= 1'b0;
      r_data    <= 64'h0;
      r_last    <= 1'b0;
      r_count   <= '0;
    end else begin
      if (w_accept) begin
        case (r_state)
          S_EMPTY: begin
            if (i_axis_last_s) begin
              // Single-word message tail: pad the low half and close the block.
              r_data <= {i_axis_data_s, PAD_WORD};
              r_last <= 1'b1;
            end else begin
              r_hi_word <= i_axis_data_s;
              r_state   <= S_HALF;
            end
          end
          S_HALF: begin
            r_data  <= {r_hi_word, i_axis_data_s};
            r_last  <= i_axis_last_s;
            r_state <= S_EMPTY;
          end
          default: r_state <= S_EMPTY;
        endcase
      end

      // A new block keeps valid high even when the previous one drains on the same edge.
      if (w_load) begin
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end

      // Count every block handed to the consumer; wraps silently.
      if (w_drain) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_axis_ready_s = w_ready_s;
  assign o_axis_valid_m = r_valid;
  assign o_axis_data_m  = r_data;
  assign o_axis_last_m  = r_last;
  assign o_block_count  = r_count;
  assign o_half_pending = (r_state == S_HALF);

endmodule
